// File: rtl/task_ctrl.sv
// rtl/task_ctrl.sv - single-task scheduler controller with priority aging and hit budget
module task_ctrl #(
   parameter int TASK_ID    = 5,
   parameter int PRIO_W     = 4,
   parameter int HIT_W      = 8,
   parameter int AGE_PERIOD = 10000,
   parameter int INIT_HIT   = 128
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              in_valid,
   input  logic [15:0]       in_op,
   output logic [3+PRIO_W:0] out_sorter,
   output logic              out_valid,
   output logic [2:0]        out_state,
   output logic              out_err
);

   localparam int AGE_W = $clog2(AGE_PERIOD);

   typedef enum logic [2:0] {
      S_READY      = 3'd0,
      S_RUNNING    = 3'd1,
      S_SUSPENDED  = 3'd2,
      S_WAIT       = 3'd3,
      S_TERMINATED = 3'd4
   } state_t;

   localparam logic [3:0] OP_READY    = 4'b0001;
   localparam logic [3:0] OP_SUSPEND  = 4'b0010;
   localparam logic [3:0] OP_WAIT     = 4'b0011;
   localparam logic [3:0] OP_KILL     = 4'b0100;
   localparam logic [3:0] OP_SETPRIO  = 4'b0101;
   localparam logic [3:0] OP_SETHIT   = 4'b0110;
   localparam logic [3:0] OP_DISPATCH = 4'b0111;
   localparam logic [3:0] OP_KILL2    = 4'b1100;
   localparam logic [3:0] OP_FINISH   = 4'b1111;

   state_t              state_q, state_d;
   logic [PRIO_W-1:0]   base_q, base_d;
   logic [PRIO_W-1:0]   eff_q, eff_d;
   logic [HIT_W-1:0]    hit_q, hit_d;
   logic [AGE_W-1:0]    age_q, age_d;
   logic                err_d;
   logic [3+PRIO_W:0]   sorter_d;

   logic [3:0] op_id, op_code, op_arg;
   logic       bcast, accepted, defined, cmd, boundary;

   logic [3:0] unused_op_hi;
   assign unused_op_hi = in_op[15:12];

   assign op_id   = in_op[11:8];
   assign op_code = in_op[7:4];
   assign op_arg  = in_op[3:0];

   // Broadcast id only carries the lifecycle opcodes; everything else stays private.
   assign bcast    = (op_id == 4'hF) && (op_code inside {OP_READY, OP_SUSPEND, OP_WAIT, OP_KILL});
   assign accepted = in_valid && ((op_id == 4'(TASK_ID)) || bcast);
   assign defined  = op_code inside {OP_READY, OP_SUSPEND, OP_WAIT, OP_KILL, OP_KILL2,
                                     OP_SETPRIO, OP_SETHIT, OP_DISPATCH, OP_FINISH};
   assign cmd      = accepted && defined;
   assign boundary = (state_q == S_READY) && (age_q == AGE_W'(AGE_PERIOD - 1));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      hit_d   = hit_q;
      eff_d   = eff_q;
      age_d   = '0;
      err_d   = 1'b0;

      if (state_q == S_READY) begin
         if (boundary) begin
            age_d = '0;
            if (eff_q != {PRIO_W{1'b1}})
               eff_d = eff_q + PRIO_W'(1);
         end else begin
            age_d = age_q + AGE_W'(1);
         end
      end

      if (cmd) begin
         // A command landing on the aging boundary swallows that aging step.
         if (boundary) begin
            age_d = '0;
            eff_d = eff_q;
         end
         case (op_code)
            OP_READY: begin
               if (state_q == S_SUSPENDED || state_q == S_WAIT) state_d = S_READY;
               else err_d = 1'b1;
            end
            OP_SUSPEND: begin
               if (state_q == S_READY || state_q == S_RUNNING || state_q == S_WAIT)
                  state_d = S_SUSPENDED;
               else err_d = 1'b1;
            end
            OP_WAIT: begin
               if (state_q == S_READY || state_q == S_RUNNING) state_d = S_WAIT;
               else err_d = 1'b1;
            end
            OP_KILL, OP_KILL2: state_d = S_TERMINATED;
            OP_SETPRIO: begin
               if (state_q == S_TERMINATED) err_d = 1'b1;
               else begin
                  base_d = PRIO_W'(op_arg);
                  eff_d  = PRIO_W'(op_arg);
                  age_d  = '0;
               end
            end
            OP_SETHIT: begin
               if (state_q == S_TERMINATED) err_d = 1'b1;
               else hit_d = HIT_W'(op_arg);
            end
            OP_DISPATCH: begin
               if (state_q == S_READY && hit_q != '0) begin
                  state_d = S_RUNNING;
                  hit_d   = hit_q - HIT_W'(1);
                  eff_d   = base_q;
                  age_d   = '0;
               end else err_d = 1'b1;
            end
            OP_FINISH: begin
               if (state_q == S_RUNNING) state_d = (hit_q != '0) ? S_READY : S_TERMINATED;
               else err_d = 1'b1;
            end
            default: ;
         endcase
      end

      if (state_d != S_READY)
         age_d = '0;

      sorter_d = (state_d == S_READY) ? {4'(TASK_ID), eff_d} : '0;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= S_READY;
         base_q     <= '0;
         eff_q      <= '0;
         hit_q      <= HIT_W'(INIT_HIT);
         age_q      <= '0;
         out_err    <= 1'b0;
         out_valid  <= 1'b1;
         out_state  <= 3'd0;
         out_sorter <= {4'(TASK_ID), {PRIO_W{1'b0}}};
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         eff_q      <= eff_d;
         hit_q      <= hit_d;
         age_q      <= age_d;
         out_err    <= err_d;
         out_valid  <= (state_d == S_READY);
         out_state  <= state_d;
         out_sorter <= sorter_d;
      end
   end

endmodule

// File: tb/tb_task_ctrl.sv
// tb/tb_task_ctrl.sv - directed self-checking bench for task_ctrl
module tb_task_ctrl;

   localparam int PRIO_W = 4;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              in_valid = 1'b0;
   logic [15:0]       in_op = '0;
   logic [3+PRIO_W:0] out_sorter;
   logic              out_valid;
   logic [2:0]        out_state;
   logic              out_err;

   int n_cmp = 0;
   int n_bad = 0;

   task_ctrl #(
      .TASK_ID(5), .PRIO_W(PRIO_W), .HIT_W(8), .AGE_PERIOD(16), .INIT_HIT(128)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_op(in_op),
      .out_sorter(out_sorter), .out_valid(out_valid), .out_state(out_state), .out_err(out_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge CLK); RST_N = 1'b0; in_valid = 1'b0;
      @(negedge CLK); RST_N = 1'b1;
   endtask

   task automatic cmd(input logic [15:0] op);
      @(negedge CLK); in_valid = 1'b1; in_op = op;
      @(negedge CLK); in_valid = 1'b0; in_op = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      // reset state and aging ramp
      reset_dut();
      chk("rst_sorter", 32'(out_sorter), 32'h50);
      chk("rst_valid",  32'(out_valid),  32'h1);
      chk("rst_state",  32'(out_state),  32'h0);
      chk("rst_err",    32'(out_err),    32'h0);
      idle(15);
      chk("age_pre_edge", 32'(out_sorter), 32'h50);
      idle(1);
      chk("age_step1", 32'(out_sorter), 32'h51);
      idle(32);
      chk("age_step3", 32'(out_sorter), 32'h53);

      // saturation and SetPrio on the aging boundary
      cmd(16'h055F);
      chk("setprio_f", 32'(out_sorter), 32'h5F);
      idle(16);
      chk("sat_hold", 32'(out_sorter), 32'h5F);
      chk("sat_err",  32'(out_err),    32'h0);
      idle(15);
      cmd(16'h0553);
      chk("bnd_setprio", 32'(out_sorter), 32'h53);
      idle(15);
      chk("bnd_restart", 32'(out_sorter), 32'h53);
      idle(1);
      chk("bnd_next_step", 32'(out_sorter), 32'h54);

      // dispatch with zero hit
      reset_dut();
      cmd(16'h0560);
      chk("sethit0_err", 32'(out_err), 32'h0);
      cmd(16'h0570);
      chk("disp0_err",    32'(out_err),    32'h1);
      chk("disp0_state",  32'(out_state),  32'h0);
      chk("disp0_sorter", 32'(out_sorter), 32'h50);
      idle(1);
      chk("err_one_cycle", 32'(out_err), 32'h0);

      // hit 1: dispatch, finish -> terminated, absorbing
      reset_dut();
      cmd(16'h0561);
      cmd(16'h0570);
      chk("run_state",  32'(out_state),  32'h1);
      chk("run_valid",  32'(out_valid),  32'h0);
      chk("run_sorter", 32'(out_sorter), 32'h0);
      cmd(16'h05F0);
      chk("fin_term", 32'(out_state), 32'h4);
      cmd(16'h0510);
      chk("term_ready_err",   32'(out_err),   32'h1);
      chk("term_ready_state", 32'(out_state), 32'h4);
      cmd(16'h0540);
      chk("term_kill_err", 32'(out_err), 32'h0);
      cmd(16'h0563);
      chk("term_sethit_err", 32'(out_err), 32'h1);

      // finish with budget left returns to ready with base priority
      reset_dut();
      cmd(16'h0557);
      cmd(16'h0570);
      cmd(16'h05F0);
      chk("fin_ready_state",  32'(out_state),  32'h0);
      chk("fin_ready_sorter", 32'(out_sorter), 32'h57);

      // broadcast and addressing
      reset_dut();
      cmd(16'h0F20);
      chk("bc_susp_state",  32'(out_state),  32'h2);
      chk("bc_susp_sorter", 32'(out_sorter), 32'h0);
      cmd(16'h0F53);
      chk("bc_setprio_err",   32'(out_err),   32'h0);
      chk("bc_setprio_state", 32'(out_state), 32'h2);
      cmd(16'h0310);
      chk("other_id_state", 32'(out_state), 32'h2);
      cmd(16'hA510);
      chk("hi_nibble_state",  32'(out_state),  32'h0);
      chk("hi_nibble_sorter", 32'(out_sorter), 32'h50);
      cmd(16'h0530);
      chk("wait_state", 32'(out_state), 32'h3);
      cmd(16'h0530);
      chk("wait_again_err",   32'(out_err),   32'h1);
      chk("wait_again_state", 32'(out_state), 32'h3);
      cmd(16'h0580);
      chk("undef_err",   32'(out_err),   32'h0);
      chk("undef_state", 32'(out_state), 32'h3);
      cmd(16'h05C0);
      chk("kill2_state", 32'(out_state), 32'h4);
      chk("kill2_err",   32'(out_err),   32'h0);

      // reset with a simultaneous kill while running
      reset_dut();
      cmd(16'h0570);
      @(negedge CLK); RST_N = 1'b0; in_valid = 1'b1; in_op = 16'h0540;
      @(negedge CLK); RST_N = 1'b1; in_valid = 1'b0; in_op = '0;
      chk("rk_state",  32'(out_state),  32'h0);
      chk("rk_err",    32'(out_err),    32'h0);
      chk("rk_sorter", 32'(out_sorter), 32'h50);
      for (int i = 1; i <= 128; i++) begin
         cmd(16'h0570);
         cmd(16'h05F0);
         if (i == 127) chk("rk_hit127_state", 32'(out_state), 32'h0);
      end
      chk("rk_hit_exhausted", 32'(out_state), 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/task_ctrl.md
TASK_CTRL -- requirements
Module: task_ctrl

Interface
REQ-001 Parameters: TASK_ID, default 5, task identifier matched against in_op[11:8].
REQ-002 Parameters: PRIO_W, default 4, effective/base priority width.
REQ-003 Parameters: HIT_W, default 8, execution-hit counter width.
REQ-004 Parameters: AGE_PERIOD, default 10000, Ready cycles per aging step, must be >=2.
REQ-005 Parameters: INIT_HIT, default 128, execution-hit value after reset.
REQ-006 Ports: CLK  in  1  single clock, all logic on rising edge.
REQ-007 Ports: RST_N  in  1  synchronous active-low reset.
REQ-008 Ports: in_valid  in  1  command strobe, one command per asserted cycle.
REQ-009 Ports: in_op  in  16  command: [15:12] ignored, [11:8] target id, [7:4] opcode, [3:0] argument.
REQ-010 Ports: out_sorter  out  4+PRIO_W  {TASK_ID[3:0], eff_prio} while READY, else all zero.
REQ-011 Ports: out_valid  out  1  high while state is READY.
REQ-012 Ports: out_state  out  3  encoded state: READY 0, RUNNING 1, SUSPENDED 2, WAIT 3, TERMINATED 4.
REQ-013 Ports: out_err  out  1  one-cycle pulse for an accepted command that is illegal in the current state.

Function
REQ-014 A command SHALL be accepted only when in_valid=1 and either in_op[11:8]==TASK_ID, or in_op[11:8]==4'hF with opcode 0001-0100 (broadcast).
REQ-015 Non-accepted cycles and undefined opcodes SHALL leave all state unchanged without out_err.
REQ-016 All outputs SHALL be registered and reflect the command one cycle after the accepting edge.
REQ-017 Opcode 0001 Ready: SUSPENDED/WAIT -> READY; RUNNING, READY and TERMINATED are illegal.
REQ-018 Opcode 0010 Suspend: READY/RUNNING/WAIT -> SUSPENDED; others are illegal.
REQ-019 Opcode 0011 Wait: READY/RUNNING -> WAIT; others are illegal.
REQ-020 Opcodes 0100 and 1100 Kill: any state -> TERMINATED, never flagged illegal.
REQ-021 Opcode 0101 SetPrio: base_prio and eff_prio <= argument (truncated or zero-extended to PRIO_W); age counter cleared; legal in every state except TERMINATED.
REQ-022 Opcode 0110 SetHit: hit <= argument zero-extended to HIT_W; legal in every state except TERMINATED.
REQ-023 Opcode 0111 Dispatch: READY with hit>0 -> RUNNING; hit decrements by 1; eff_prio <= base_prio; age cleared. Any other condition is illegal.
REQ-024 Opcode 1111 Finish: RUNNING -> READY if hit>0, else RUNNING -> TERMINATED. Any other state is illegal.
REQ-025 An illegal command SHALL cause no state, priority or hit change and SHALL pulse out_err for one cycle.
REQ-026 TERMINATED SHALL be absorbing; only reset leaves it.
REQ-027 Aging: in READY, the age counter increments each cycle. On reaching AGE_PERIOD-1 it wraps to 0 and eff_prio increments, saturating at 2^PRIO_W-1. In other states the age counter is held at 0.
REQ-028 If a command is accepted in an aging-boundary cycle, the command result SHALL win; the aging step is dropped and the counter cleared.
REQ-029 The hit counter SHALL never underflow, and eff_prio SHALL never wrap.

Reset
REQ-030 When RST_N=0 at a rising edge: state READY, base_prio=0, eff_prio=0, hit=INIT_HIT, age=0, out_err=0. On the next cycle out_sorter={TASK_ID,0} and out_valid=1.
REQ-031 Reset SHALL override any command in the same cycle, including during RUNNING or in mid-aging.

Verification
REQ-032 Reset, then idle for AGE_PERIOD*3 cycles -> eff_prio steps 0->1->2->3; out_sorter = 0x53 at defaults.
REQ-033 SetHit arg 1, Dispatch, Finish -> state goes RUNNING then TERMINATED; a following Ready pulses out_err and the state stays 4.
REQ-034 Dispatch with hit=0 -> out_err pulses, state stays READY, out_sorter unchanged.
REQ-035 Broadcast id 0xF Suspend -> SUSPENDED and out_sorter=0. Broadcast SetPrio -> ignored, no out_err.
REQ-036 SetPrio 0xF, then age one more period -> eff_prio stays 0xF. SetPrio issued on an aging-boundary cycle -> eff_prio equals the argument and age restarts at 0.
REQ-037 RST_N low during RUNNING with a simultaneous Kill -> the next cycle shows READY, hit=INIT_HIT, out_err=0.
